// File: rtl/csa_serial_accum_if.sv
// Handshake bundle for csa_serial_accum: word input stream, result output stream, group word count.
interface csa_serial_accum_if #(
    parameter int N     = 8,
    parameter int K     = 10,
    parameter int CBITS = 4
);
    localparam int SBITS = N + CBITS;
    localparam int CW    = $clog2(K + 1);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_word;
    logic             out_valid;
    logic             out_ready;
    logic [SBITS-1:0] out_sum;
    logic             out_ovf;
    logic [CW-1:0]    word_cnt;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, word_cnt
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, word_cnt
    );
endinterface

// File: rtl/csa_serial_accum.sv
// Streaming multi-operand adder: K words folded into a carry-save pair, one final
// carry-propagate resolve, result held on a valid/ready port until taken.
//
// state   | meaning
// ACCUM   | accepting words, one 3:2 compression per accept
// RESOLVE | carry-propagate add of ps+pc into the output register
// HOLD    | result presented, waiting for out_ready
module csa_serial_accum #(
    parameter int N     = 8,
    parameter int K     = 10,
    parameter int CBITS = 4
) (
    input logic             clk,
    input logic             rst_n,
    csa_serial_accum_if.slave bus
);
    localparam int SBITS = N + CBITS;
    localparam int CW    = $clog2(K + 1);

    typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SBITS-1:0] ps;
    logic [SBITS-1:0] pc;
    logic [SBITS-1:0] w;
    logic [SBITS-1:0] maj;
    logic [SBITS-1:0] sum_q;
    logic [SBITS:0]   resolved;
    logic [CW-1:0]    cnt;
    logic             ovf_acc;
    logic             ovf_q;
    logic             accept;
    logic             deliver;
    logic             last_word;
    logic             in_ready;
    logic             out_valid;

    assign w         = SBITS'(bus.in_word);
    assign maj       = (ps & pc) | (ps & w) | (pc & w);
    assign accept    = in_ready && bus.in_valid;
    assign deliver   = out_valid && bus.out_ready;
    assign last_word = (cnt == CW'(K - 1));
    assign resolved  = {1'b0, ps} + {1'b0, pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && last_word) state_nxt = RESOLVE;
            end
            RESOLVE: state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // The top majority bit falls off the left shift; since every operand is
    // non-negative, any such dropped carry means the true sum overflowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps      <= '0;
            pc      <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                ps      <= ps ^ pc ^ w;
                pc      <= {maj[SBITS-2:0], 1'b0};
                ovf_acc <= ovf_acc | maj[SBITS-1];
                cnt     <= cnt + CW'(1);
            end
            if (state == RESOLVE) begin
                sum_q <= resolved[SBITS-1:0];
                ovf_q <= ovf_acc | resolved[SBITS];
            end
            if (deliver) begin
                ps      <= '0;
                pc      <= '0;
                cnt     <= '0;
                ovf_acc <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.word_cnt  = cnt;
endmodule

// File: tb/tb_csa_serial_accum.sv
// Bench for csa_serial_accum: three builds (K=10/CBITS=4, K=10/CBITS=2, K=1) checked
// against a plain integer-sum model of each word group.
module tb_csa_serial_accum;
    localparam int NA = 4;
    localparam int KA = 10;
    localparam int CA = 4;
    localparam int SA = NA + CA;
    localparam int WA = $clog2(KA + 1);
    localparam int CB = 2;
    localparam int SB = NA + CB;
    localparam int KC = 1;
    localparam int SC = NA + CA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_serial_accum_if #(.N(NA), .K(KA), .CBITS(CA)) ifa ();
    csa_serial_accum_if #(.N(NA), .K(KA), .CBITS(CB)) ifb ();
    csa_serial_accum_if #(.N(NA), .K(KC), .CBITS(CA)) ifc ();

    csa_serial_accum #(.N(NA), .K(KA), .CBITS(CA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    csa_serial_accum #(.N(NA), .K(KA), .CBITS(CB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    csa_serial_accum #(.N(NA), .K(KC), .CBITS(CA)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    function automatic longint model_total(input int words[$]);
        longint t = 0;
        foreach (words[i]) t += words[i];
        return t;
    endfunction

    task automatic push_a(input int words[$], input bit bubbles, output int last_edge, output int cnt_bad);
        int i = 0;
        int budget = 0;
        last_edge = -1;
        cnt_bad = 0;
        while (i < words.size() && budget < 400) begin
            @(negedge clk);
            budget++;
            ifa.in_valid = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
            ifa.in_word  = 4'(words[i]);
            if (ifa.in_ready) begin
                if (ifa.word_cnt !== WA'(i)) cnt_bad++;
                if (ifa.in_valid) begin
                    last_edge = cyc + 1;
                    i++;
                end
            end
        end
        if (i < words.size()) cnt_bad += 1000;
    endtask

    task automatic wait_result_a(input int last_edge, input bit hold, output int lat,
                                 output logic [SA-1:0] sum, output logic ovf, output int stall_rdy);
        lat = -1;
        stall_rdy = 0;
        sum = '0;
        ovf = 1'b0;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            ifa.in_valid = hold;
            ifa.in_word  = 4'($urandom);
            if (ifa.in_ready) stall_rdy++;
            if (ifa.out_valid) begin
                lat = cyc - last_edge;
                sum = ifa.out_sum;
                ovf = ifa.out_ovf;
            end
        end
    endtask

    task automatic run_group_a(input string name, input int words[$], input bit bubbles);
        int               le, cb, lat, sr;
        logic [SA-1:0]    sum;
        logic             ovf;
        longint           total = model_total(words);
        logic [SA-1:0]    exp_sum = SA'(total % (64'd1 << SA));
        logic             exp_ovf = (total >= (64'd1 << SA));
        ifa.out_ready = 1'b1;
        push_a(words, bubbles, le, cb);
        wait_result_a(le, 1'b0, lat, sum, ovf, sr);
        checks++;
        if (cb !== 0) begin
            errors++;
            $display("FAIL %s_wordcnt: bad word_cnt samples %0d, want 0", name, cb);
        end
        checks++;
        if (lat !== 1 || sr !== 0) begin
            errors++;
            $display("FAIL %s_latency: out_valid %0d edges after last accept with %0d ready cycles, want 1 and 0", name, lat, sr);
        end
        checks++;
        if (sum !== exp_sum || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s_result: sum=%0d ovf=%b, want sum=%0d ovf=%b", name, sum, ovf, exp_sum, exp_ovf);
        end
        @(negedge clk);
        checks++;
        if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.word_cnt !== '0) begin
            errors++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b word_cnt=%0d, want 1 0 0",
                     name, ifa.in_ready, ifa.out_valid, ifa.word_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.out_sum !== '0 ||
            ifa.out_ovf !== 1'b0 || ifa.word_cnt !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b sum=%0d ovf=%b cnt=%0d, want 1 0 0 0 0",
                     ifa.in_ready, ifa.out_valid, ifa.out_sum, ifa.out_ovf, ifa.word_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int q[$] = '{11, 2, 13, 4, 5, 6, 7, 8, 9, 10};
        run_group_a("directed", q, 1'b0);
    endtask

    task automatic test_all_ones();
        int qf[$];
        int q1[$];
        for (int i = 0; i < KA; i++) begin
            qf.push_back(15);
            q1.push_back(1);
        end
        run_group_a("all_f", qf, 1'b0);
        run_group_a("all_1_after_f", q1, 1'b0);
    endtask

    task automatic test_bubbles();
        int q[$] = '{11, 2, 13, 4, 5, 6, 7, 8, 9, 10};
        run_group_a("bubbles", q, 1'b1);
    endtask

    task automatic test_random();
        for (int g = 0; g < 4; g++) begin
            int q[$];
            for (int i = 0; i < KA; i++) q.push_back(int'($urandom_range(0, 15)));
            run_group_a("random", q, g[0]);
        end
    endtask

    task automatic test_backpressure();
        int            q[$];
        int            le, cb, lat, sr;
        int            bad = 0;
        logic [SA-1:0] sum;
        logic          ovf;
        longint        total;
        for (int i = 0; i < KA; i++) q.push_back(int'($urandom_range(0, 15)));
        total = model_total(q);
        ifa.out_ready = 1'b0;
        push_a(q, 1'b0, le, cb);
        wait_result_a(le, 1'b1, lat, sum, ovf, sr);
        checks++;
        if (lat !== 1 || sum !== SA'(total) || ovf !== (total >= (64'd1 << SA))) begin
            errors++;
            $display("FAIL bp_result: lat=%0d sum=%0d ovf=%b, want lat=1 sum=%0d", lat, sum, ovf, total);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ifa.in_valid = 1'b1;
            ifa.in_word  = 4'($urandom);
            if (ifa.out_valid !== 1'b1 || ifa.out_sum !== SA'(total) || ifa.in_ready !== 1'b0 ||
                ifa.word_cnt !== WA'(KA)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable stall cycles, want 0", bad);
        end
        ifa.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0 || ifa.word_cnt !== '0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b word_cnt=%0d, want 1 0 0",
                     ifa.in_ready, ifa.out_valid, ifa.word_cnt);
        end
        ifa.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int            q3[$] = '{3, 3, 3, 3};
        int            q1[$];
        int            qr[$];
        int            le, cb, lat, sr;
        logic [SA-1:0] sum;
        logic          ovf;
        ifa.out_ready = 1'b1;
        push_a(q3, 1'b0, le, cb);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.word_cnt !== '0 || ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_group: word_cnt=%0d in_ready=%b out_valid=%b, want 0 1 0",
                     ifa.word_cnt, ifa.in_ready, ifa.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < KA; i++) qr.push_back(15);
        ifa.out_ready = 1'b0;
        push_a(qr, 1'b0, le, cb);
        wait_result_a(le, 1'b0, lat, sum, ovf, sr);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.out_sum !== '0 || ifa.out_ovf !== 1'b0 ||
            ifa.in_ready !== 1'b1 || ifa.word_cnt !== '0) begin
            errors++;
            $display("FAIL reset_in_hold: vld=%b sum=%0d ovf=%b rdy=%b cnt=%0d, want 0 0 0 1 0",
                     ifa.out_valid, ifa.out_sum, ifa.out_ovf, ifa.in_ready, ifa.word_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < KA; i++) q1.push_back(1);
        run_group_a("after_reset", q1, 1'b0);
    endtask

    task automatic test_small_cbits();
        for (int g = 0; g < 3; g++) begin
            int            q[$];
            int            bad = 0;
            bit            got = 1'b0;
            logic [SB-1:0] sum = '0;
            logic          ovf = 1'b0;
            longint        total;
            for (int i = 0; i < KA; i++) q.push_back(g == 0 ? 15 : int'($urandom_range(0, 15)));
            total = model_total(q);
            for (int i = 0; i < KA; i++) begin
                @(negedge clk);
                ifb.in_valid = 1'b1;
                ifb.in_word  = 4'(q[i]);
                if (ifb.in_ready !== 1'b1) bad++;
            end
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                ifb.in_valid = 1'b0;
                if (ifb.out_valid) begin
                    got = 1'b1;
                    sum = ifb.out_sum;
                    ovf = ifb.out_ovf;
                end
            end
            checks++;
            if (!got || bad !== 0 || sum !== SB'(total % 64) || ovf !== (total >= 64)) begin
                errors++;
                $display("FAIL cbits2_group%0d: got=%b stalls=%0d sum=%0d ovf=%b, want sum=%0d ovf=%b",
                         g, got, bad, sum, ovf, total % 64, total >= 64);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_k1();
        for (int g = 0; g < 6; g++) begin
            int w = (g == 0) ? 9 : int'($urandom_range(0, 15));
            int t;
            int bad = 0;
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.in_word  = 4'(w);
            if (ifc.in_ready !== 1'b1) bad++;
            t = cyc + 1;
            @(negedge clk);
            ifc.in_valid = 1'b0;
            if (cyc !== t || ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b0) bad++;
            @(negedge clk);
            checks++;
            if (bad !== 0 || ifc.out_valid !== 1'b1 || ifc.out_sum !== SC'(w) || ifc.out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL k1_word%0d: vld=%b sum=%0d ovf=%b timing_errs=%0d, want vld=1 sum=%0d ovf=0",
                         g, ifc.out_valid, ifc.out_sum, ifc.out_ovf, bad, w);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.in_word = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_word = '0; ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_word = '0; ifc.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_all_ones();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_small_cbits();
        test_k1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
